// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline: canonical NOP and fetch-stage
// controller states.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDiscard,
    StHold
  } fetch_state_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: flush beats stall beats load; idle cycles insert a
// bubble. PC fields survive bubbles so decode keeps a stable PC for debug.
module if_id_register
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pcplus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pcplus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, pc_q, pcplus4_q;
  logic        valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= NOP_INSTR;
      pc_q      <= '0;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (!stall_i) begin
      if (load_i) begin
        instr_q   <= instr_i;
        pc_q      <= pc_i;
        pcplus4_q <= pcplus4_i;
        valid_q   <= 1'b1;
      end else begin
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
      end
    end
  end

  assign instr_o   = instr_q;
  assign pc_o      = pc_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns PCF, keeps at most one imem request in flight,
// squashes wrong-path responses and parks a stalled response in a skid buffer.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  output logic        ImemReqValid,
  output logic [31:0] ImemAddr,
  input  logic        ImemReqReady,
  input  logic        ImemRespValid,
  input  logic [31:0] ImemRdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        InstrValidD
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pcf_q, pc_next;
  logic [31:0]  skid_q, skid_d;
  logic [31:0]  redirect_addr;
  logic [31:0]  deliver_instr;
  logic         deliver, req_valid, issue;

  // Bit 0 cleared for JALR targets; bit 1 deliberately passed through.
  assign redirect_addr = PCTargetE & 32'hFFFF_FFFE;

  always_comb begin
    state_d       = state_q;
    skid_d        = skid_q;
    deliver       = 1'b0;
    deliver_instr = ImemRdata;
    req_valid     = 1'b0;
    issue         = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_valid = !StallF || PCSrcE;
        issue     = 1'b1;
      end
      StWait: begin
        if (PCSrcE) begin
          if (ImemRespValid) begin
            req_valid = 1'b1;
            issue     = 1'b1;
          end else begin
            state_d = StDiscard;
          end
        end else if (ImemRespValid) begin
          if (!StallD) begin
            deliver   = 1'b1;
            req_valid = !StallF;
            issue     = 1'b1;
          end else begin
            skid_d  = ImemRdata;
            state_d = StHold;
          end
        end
      end
      StDiscard: begin
        if (ImemRespValid) begin
          req_valid = !StallF || PCSrcE;
          issue     = 1'b1;
        end
      end
      StHold: begin
        if (PCSrcE || !StallD) state_d = StIdle;
        if (!PCSrcE && !StallD) begin
          deliver       = 1'b1;
          deliver_instr = skid_q;
        end
      end
      default: state_d = StIdle;
    endcase

    if (issue) state_d = (req_valid && ImemReqReady) ? StWait : StIdle;

    if (PCSrcE)       pc_next = redirect_addr;
    else if (deliver) pc_next = pcf_q + 32'd4;
    else              pc_next = pcf_q;
  end

  // PCF always tracks PCNextF, which equals ImemAddr whenever a request fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pcf_q   <= RESET_PC;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      pcf_q   <= pc_next;
      skid_q  <= skid_d;
    end
  end

  assign ImemReqValid = req_valid;
  assign ImemAddr     = pc_next;

  if_id_register u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (FlushD),
    .stall_i   (StallD),
    .load_i    (deliver),
    .instr_i   (deliver_instr),
    .pc_i      (pcf_q),
    .pcplus4_i (pcf_q + 32'd4),
    .instr_o   (InstrD),
    .pc_o      (PCD),
    .pcplus4_o (PCPlus4D),
    .valid_o   (InstrValidD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: wait-state memory model, expected-PC scoreboard,
// table of streaming scenarios plus redirect / skid / flush sequences.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCSrcE, StallF, StallD, FlushD;
  logic [31:0] PCTargetE;
  logic        ImemReqValid, ImemReqReady, ImemRespValid;
  logic [31:0] ImemAddr, ImemRdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        InstrValidD;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PCSrcE        (PCSrcE),
    .PCTargetE     (PCTargetE),
    .StallF        (StallF),
    .StallD        (StallD),
    .FlushD        (FlushD),
    .ImemReqValid  (ImemReqValid),
    .ImemAddr      (ImemAddr),
    .ImemReqReady  (ImemReqReady),
    .ImemRespValid (ImemRespValid),
    .ImemRdata     (ImemRdata),
    .InstrD        (InstrD),
    .PCD           (PCD),
    .PCPlus4D      (PCPlus4D),
    .InstrValidD   (InstrValidD)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0003;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: response arrives mem_wait+1 cycles after the request fires.
  int          mem_wait = 0;
  logic        busy = 1'b0;
  int          cnt = 0;
  logic [31:0] maddr = '0;
  logic        resp_now = 1'b0, fire_now = 1'b0;
  logic [31:0] fire_addr = '0;

  initial begin
    ImemReqReady  = 1'b1;
    ImemRespValid = 1'b0;
    ImemRdata     = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        busy = 1'b0;
      end else begin
        if (resp_now) busy = 1'b0;
        else if (busy && cnt > 0) cnt--;
        if (fire_now) begin
          busy  = 1'b1;
          cnt   = mem_wait;
          maddr = fire_addr;
        end
      end
      ImemRespValid = busy && cnt == 0;
      ImemRdata     = ImemRespValid ? mem_word(maddr) : 32'hBAD0_BAD0;
    end
  end

  // Scoreboard of expected delivered PCs plus delivery-spacing check.
  logic [31:0] exp_q[$];
  logic        ld_prev = 1'b0;
  logic        gap_on = 1'b0;
  logic        first_pending = 1'b0;
  int          mon_last = 0;
  int          exp_gap = 1;
  int          c0 = 0;

  always @(negedge clk) begin
    logic [31:0] e;
    resp_now  = rst_n && ImemRespValid;
    fire_now  = rst_n && ImemReqValid && ImemReqReady;
    fire_addr = ImemAddr;
    if (!rst_n) begin
      ld_prev = 1'b0;
    end else begin
      if (busy && !ImemRespValid) chk("one_outstanding", 32'(ImemReqValid), 32'd0);
      if (ld_prev && InstrValidD && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_pcd", PCD, e);
        chk("sb_instr", InstrD, mem_word(e));
        chk("sb_pcplus4", PCPlus4D, e + 32'd4);
        if (gap_on) begin
          chk("deliver_gap", 32'(cyc - mon_last), 32'(first_pending ? exp_gap + 1 : exp_gap));
          first_pending = 1'b0;
          mon_last      = cyc;
        end
      end
      ld_prev = !StallD && !FlushD;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int w);
    mem_wait = w;
    PCSrcE   = 1'b0;
    StallF   = 1'b0;
    StallD   = 1'b0;
    FlushD   = 1'b0;
    gap_on   = 1'b0;
    exp_q.delete();
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_instr", InstrD, NOP_INSTR);
    chk("rst_pcd", PCD, 32'd0);
    chk("rst_pcplus4", PCPlus4D, 32'd0);
    chk("rst_valid", 32'(InstrValidD), 32'd0);
    chk("rst_addr", ImemAddr, RPC);
    step();
    rst_n = 1'b1;
    c0    = cyc;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 400 && exp_q.size() > 0; k++) @(posedge clk);
    #1;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    int          w;
    logic        redir;
    logic [31:0] tgt;
    int          n;
    logic [31:0] exp_start;
    int          exp_gap;
  } row_t;

  row_t rows[4];

  initial begin
    logic [31:0] pd;
    PCSrcE    = 1'b0;
    PCTargetE = '0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;

    rows[0] = '{w: 0, redir: 1'b0, tgt: 32'h0,         n: 6, exp_start: 32'h100,       exp_gap: 1};
    rows[1] = '{w: 3, redir: 1'b0, tgt: 32'h0,         n: 4, exp_start: 32'h100,       exp_gap: 4};
    rows[2] = '{w: 1, redir: 1'b1, tgt: 32'h301,       n: 4, exp_start: 32'h300,       exp_gap: 2};
    rows[3] = '{w: 0, redir: 1'b1, tgt: 32'hFFFF_FFF4, n: 4, exp_start: 32'hFFFF_FFF4, exp_gap: 1};

    for (int r = 0; r < 4; r++) begin
      do_reset(rows[r].w);
      for (int i = 0; i < rows[r].n; i++) exp_q.push_back(rows[r].exp_start + 32'(4 * i));
      exp_gap       = rows[r].exp_gap;
      mon_last      = c0;
      first_pending = 1'b1;
      gap_on        = 1'b1;
      if (rows[r].redir) begin
        PCSrcE    = 1'b1;
        PCTargetE = rows[r].tgt;
      end
      @(negedge clk);
      chk("first_req_valid", 32'(ImemReqValid), 32'd1);
      chk("first_req_addr", ImemAddr, rows[r].exp_start);
      step();
      PCSrcE = 1'b0;
      drain("row_drain");
    end

    // Redirect while a slow response is outstanding: stale word must be dropped.
    do_reset(3);
    step();
    PCSrcE    = 1'b1;
    PCTargetE = 32'h201;
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    @(negedge clk);
    chk("redir_noreq", 32'(ImemReqValid), 32'd0);
    step();
    PCSrcE = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("redir_req_valid", 32'(ImemReqValid), 32'd1);
    chk("redir_req_addr", ImemAddr, 32'h200);
    drain("redir_drain");

    // StallD over an arriving response: word parks, then appears on release.
    do_reset(0);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    step();
    step();
    StallD = 1'b1;
    @(negedge clk);
    chk("stall_noreq", 32'(ImemReqValid), 32'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      @(negedge clk);
      chk("hold_noreq", 32'(ImemReqValid), 32'd0);
      chk("hold_pcd", PCD, 32'h100);
      chk("hold_instr", InstrD, mem_word(32'h100));
      chk("hold_valid", 32'(InstrValidD), 32'd1);
    end
    step();
    StallD = 1'b0;
    step();
    @(negedge clk);
    chk("skid_pcd", PCD, 32'h104);
    chk("skid_instr", InstrD, mem_word(32'h104));
    chk("after_hold_addr", ImemAddr, 32'h108);
    drain("skid_drain");

    // FlushD together with StallD: flush wins, PC fields untouched.
    step();
    pd     = PCD;
    StallD = 1'b1;
    FlushD = 1'b1;
    step();
    StallD = 1'b0;
    FlushD = 1'b0;
    @(negedge clk);
    chk("flush_instr", InstrD, NOP_INSTR);
    chk("flush_valid", 32'(InstrValidD), 32'd0);
    chk("flush_pcd", PCD, pd);

    // Reset mid-stream, then the fetch restarts cleanly at RESET_PC.
    step();
    do_reset(0);
    exp_q.push_back(RPC);
    @(negedge clk);
    chk("rerst_addr", ImemAddr, RPC);
    drain("rerst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
